// File: rtl/rx_frame_tracker_pkg.sv
// rx_frame_tracker_pkg: shared state encoding, default parameters and info-entry layout
package rx_frame_tracker_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_INFO_DEPTH = 4;
  localparam int DEF_CNT_W      = 12;
  localparam int DEF_GAP_BAUDS  = 17;
  localparam int MS_W           = 12;
  localparam int US_W           = 4;
  localparam int STAMP_W        = MS_W + US_W;
  localparam int INFO_CNT_LSB   = 0;
  function automatic int info_ms_lsb(input int cnt_w);
    return cnt_w;
  endfunction
  function automatic int info_us_lsb(input int cnt_w);
    return cnt_w + MS_W;
  endfunction
endpackage

// File: rtl/rx_info_fifo.sv
// rx_info_fifo: first-word-fall-through FIFO that overwrites its oldest entry when pushed while full
module rx_info_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, pop;
  always_comb begin
    pop = pop_i && cnt_q != '0;
    ovf_d = push_i && cnt_q == CW'(DEPTH) && !pop;
    rd_d = (pop || ovf_d) ? rd_q + 1'b1 : rd_q;
    wr_d = push_i ? wr_q + 1'b1 : wr_q;
    cnt_d = cnt_q + CW'(push_i && !ovf_d) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= din_i;
  assign valid_o = cnt_q != '0;
  assign dout_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/rx_frame_tracker.sv
// rx_frame_tracker: checks received characters, forwards good ones to the data FIFO,
// and logs {stamp, count} of each idle-gap-delimited frame in an info FIFO.
module rx_frame_tracker
  import rx_frame_tracker_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int INFO_DEPTH = DEF_INFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_BAUDS  = DEF_GAP_BAUDS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          byte_synch_i,
  input  logic [DATA_W+2:0]             byte_i,
  input  logic                          baud_sig_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          big_end_i,
  input  logic [MS_W-1:0]               ms_stamp_i,
  input  logic [US_W-1:0]               us100_stamp_i,
  output logic                          n_we_o,
  output logic [DATA_W-1:0]             data_o,
  input  logic                          p_full_i,
  input  logic                          info_rd_i,
  output logic [STAMP_W+CNT_W-1:0]      info_o,
  output logic                          info_valid_o,
  output logic [$clog2(INFO_DEPTH):0]   info_count_o,
  output logic                          parity_err_o,
  output logic                          stop_err_o,
  output logic                          data_ovf_o,
  output logic                          info_ovf_o
);
  localparam int INFO_W = STAMP_W + CNT_W;
  localparam int MS_LSB = info_ms_lsb(CNT_W);
  localparam int US_LSB = info_us_lsb(CNT_W);
  localparam logic [7:0] GAP_END = 8'(GAP_BAUDS);
  state_t state_q, state_d;
  logic [DATA_W+1:0] chr_q, chr_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d, fstamp_q, fstamp_d;
  logic [CNT_W-1:0] fcount_q, fcount_d;
  logic [7:0] gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d, data, rev;
  logic fopen_q, fopen_d, n_we_q, n_we_d, perr_q, perr_d, serr_q, serr_d, dovf_q, dovf_d;
  logic take, in_check, par_bad, stop_bad, accept, close;
  logic [INFO_W-1:0] info_push;
  logic unused_start;
  assign unused_start = byte_i[DATA_W+2];
  always_comb begin
    state_d = state_q == IDLE ? (byte_synch_i ? CHECK : IDLE) : state_q == CHECK ? WRITE : IDLE;
    take = state_q == IDLE && byte_synch_i;
    in_check = state_q == CHECK;
    data = chr_q[DATA_W+1:2];
    for (int i = 0; i < DATA_W; i++) rev[i] = data[DATA_W-1-i];
    par_bad = parity_en_i && ((^data ^ parity_odd_i) != chr_q[1]);
    stop_bad = !chr_q[0];
    accept = in_check && !par_bad && !stop_bad && !p_full_i;
    close = fopen_q && gap_q == GAP_END && !byte_synch_i;
    chr_d = take ? byte_i[DATA_W+1:0] : chr_q;
    stamp_d = take ? {us100_stamp_i, ms_stamp_i} : stamp_q;
    gap_d = byte_synch_i ? 8'd0 : (baud_sig_i && gap_q != 8'hFF) ? gap_q + 8'd1 : gap_q;
    fopen_d = accept ? 1'b1 : close ? 1'b0 : fopen_q;
    fstamp_d = (accept && !fopen_q) ? stamp_q : fstamp_q;
    fcount_d = !accept ? fcount_q : !fopen_q ? CNT_W'(1) : &fcount_q ? fcount_q : fcount_q + 1'b1;
    n_we_d = !accept;
    data_d = accept ? (big_end_i ? data : rev) : data_q;
    perr_d = in_check && par_bad;
    serr_d = in_check && stop_bad;
    dovf_d = (in_check && !par_bad && !stop_bad && p_full_i) || (byte_synch_i && state_q != IDLE);
    info_push = '0;
    info_push[INFO_CNT_LSB +: CNT_W] = fcount_q;
    info_push[MS_LSB +: MS_W] = fstamp_q[0 +: MS_W];
    info_push[US_LSB +: US_W] = fstamp_q[MS_W +: US_W];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chr_q <= '0;
      stamp_q <= '0;
      fstamp_q <= '0;
      fcount_q <= '0;
      fopen_q <= 1'b0;
      gap_q <= 8'hFF;
      n_we_q <= 1'b1;
      data_q <= '0;
      perr_q <= 1'b0;
      serr_q <= 1'b0;
      dovf_q <= 1'b0;
    end else begin
      chr_q <= chr_d;
      stamp_q <= stamp_d;
      fstamp_q <= fstamp_d;
      fcount_q <= fcount_d;
      fopen_q <= fopen_d;
      gap_q <= gap_d;
      n_we_q <= n_we_d;
      data_q <= data_d;
      perr_q <= perr_d;
      serr_q <= serr_d;
      dovf_q <= dovf_d;
    end
  end
  rx_info_fifo #(.DEPTH(INFO_DEPTH), .WIDTH(INFO_W)) u_info (
    .clk(clk),
    .rst(rst),
    .push_i(close),
    .din_i(info_push),
    .pop_i(info_rd_i),
    .dout_o(info_o),
    .valid_o(info_valid_o),
    .count_o(info_count_o),
    .ovf_o(info_ovf_o)
  );
  assign n_we_o = n_we_q;
  assign data_o = data_q;
  assign parity_err_o = perr_q;
  assign stop_err_o = serr_q;
  assign data_ovf_o = dovf_q;
endmodule

// File: tb/tb_rx_frame_tracker.sv
// tb_rx_frame_tracker: directed plus randomized checks of rx_frame_tracker against a frame-level model
module tb_rx_frame_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bs = 1'b0, baud = 1'b0, pen = 1'b0, podd = 1'b0, bigend = 1'b1, pfull = 1'b0, rd = 1'b0;
  logic [10:0] b_in = '0;
  logic [11:0] ms = '0;
  logic [3:0] us = '0;
  logic n_we, perr, serr, dovf, iovf, ivalid;
  logic [7:0] dout;
  logic [27:0] info;
  logic [2:0] icount;
  int checks = 0, failures = 0;
  logic [27:0] exp_q[$];
  logic [7:0] exp_data;
  bit open;
  int cnt, gap;
  logic [15:0] fstamp;

  always #5 clk = ~clk;

  rx_frame_tracker dut (
    .clk(clk), .rst(rst), .byte_synch_i(bs), .byte_i(b_in), .baud_sig_i(baud),
    .parity_en_i(pen), .parity_odd_i(podd), .big_end_i(bigend),
    .ms_stamp_i(ms), .us100_stamp_i(us), .n_we_o(n_we), .data_o(dout), .p_full_i(pfull),
    .info_rd_i(rd), .info_o(info), .info_valid_o(ivalid), .info_count_o(icount),
    .parity_err_o(perr), .stop_err_o(serr), .data_ovf_o(dovf), .info_ovf_o(iovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    open = 0;
    cnt = 0;
    gap = 255;
    exp_data = '0;
  endtask

  task automatic check_info();
    chk("info_valid", ivalid, exp_q.size() != 0);
    chk("info_count", icount, exp_q.size());
    chk("info_o", info, exp_q.size() != 0 ? exp_q[0] : 28'h0);
  endtask

  task automatic send(input logic [7:0] d, input logic pbit, input logic stop, input logic pf, input bit dup);
    logic pb, sb, acc;
    logic [7:0] rv;
    logic [15:0] st;
    st = 16'($urandom);
    ms = st[11:0];
    us = st[15:12];
    b_in = {1'b0, d, pbit, stop};
    bs = 1'b1;
    pfull = pf;
    step();
    bs = dup;
    b_in = {1'b0, ~d, ~pbit, stop};
    step();
    bs = 1'b0;
    pfull = 1'b0;
    pb = pen && ((^d ^ podd) != pbit);
    sb = !stop;
    acc = !pb && !sb && !pf;
    for (int i = 0; i < 8; i++) rv[i] = d[7-i];
    if (acc) exp_data = bigend ? d : rv;
    chk("n_we_n2", n_we, !acc);
    chk("data_o", dout, exp_data);
    chk("parity_err", perr, pb);
    chk("stop_err", serr, sb);
    chk("data_ovf", dovf, (!pb && !sb && pf) || dup);
    gap = 0;
    if (acc) begin
      if (!open) begin
        open = 1;
        fstamp = st;
        cnt = 1;
      end else if (cnt < 4095) cnt++;
    end
    step();
    chk("n_we_n3", n_we, 1'b1);
    chk("err_pulse_end", {perr, serr, dovf}, 3'b000);
  endtask

  task automatic tick(input bit rdc);
    bit ovf;
    baud = 1'b1;
    step();
    baud = 1'b0;
    rd = rdc;
    step();
    rd = 1'b0;
    ovf = 0;
    if (gap < 255) gap++;
    if (rdc && exp_q.size() != 0) void'(exp_q.pop_front());
    if (open && gap == 17) begin
      if (exp_q.size() == 4) begin
        void'(exp_q.pop_front());
        ovf = 1;
      end
      exp_q.push_back({fstamp, 12'(cnt)});
      open = 0;
    end
    chk("info_ovf", iovf, ovf);
    check_info();
  endtask

  task automatic pop_info();
    check_info();
    rd = 1'b1;
    step();
    rd = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check_info();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(0);
  endtask

  initial begin
    logic [7:0] d;
    logic [27:0] head3;
    int ovf_seen;
    model_reset();
    step();
    step();
    chk("rst_n_we", n_we, 1'b1);
    chk("rst_data", dout, 8'h00);
    chk("rst_errs", {perr, serr, dovf, iovf}, 4'h0);
    check_info();
    rst = 1'b0;
    step();
    // basic writes and bit order
    send(8'hA5, 1'b0, 1'b1, 1'b0, 0);
    chk("a5_big", dout, 8'hA5);
    bigend = 1'b0;
    send(8'hA5, 1'b0, 1'b1, 1'b0, 0);
    chk("a5_rev", dout, 8'hA5);
    send(8'h01, 1'b0, 1'b1, 1'b0, 0);
    chk("01_rev", dout, 8'h80);
    bigend = 1'b1;
    // parity and stop faults
    pen = 1'b1;
    podd = 1'b0;
    send(8'h03, 1'b1, 1'b1, 1'b0, 0);
    send(8'h03, 1'b0, 1'b0, 1'b0, 0);
    send(8'h07, 1'b0, 1'b0, 1'b0, 0);
    podd = 1'b1;
    send(8'h07, 1'b0, 1'b1, 1'b0, 0);
    pen = 1'b0;
    ticks(17);
    chk("frame1_count", info[11:0], 12'd4);
    pop_info();
    // three characters 10 ticks apart then a 17-tick gap
    send(8'h11, 1'b0, 1'b1, 1'b0, 0);
    ticks(10);
    send(8'h22, 1'b0, 1'b1, 1'b0, 0);
    ticks(10);
    send(8'h33, 1'b0, 1'b1, 1'b0, 0);
    ticks(16);
    chk("no_early_close", ivalid, 1'b0);
    ticks(1);
    chk("frame3_count", info[11:0], 12'd3);
    pop_info();
    // six frames, no reads
    ovf_seen = 0;
    for (int f = 0; f < 6; f++) begin
      send(8'(f), 1'b0, 1'b1, 1'b0, 0);
      for (int t = 0; t < 17; t++) begin
        tick(0);
        if (iovf) ovf_seen++;
        if (f == 2 && t == 16) head3 = exp_q[exp_q.size()-1];
      end
    end
    chk("ovf_twice", ovf_seen, 2);
    chk("head_frame3", info, head3);
    // pop coinciding with a close on a full FIFO
    send(8'h5A, 1'b0, 1'b1, 1'b0, 0);
    ticks(16);
    tick(1);
    chk("full_pop_push_cnt", icount, 3'd4);
    for (int i = 0; i < 5; i++) pop_info();
    // data FIFO full and busy-time overrun
    send(8'hC3, 1'b0, 1'b1, 1'b1, 0);
    send(8'h3C, 1'b0, 1'b1, 1'b0, 1);
    send(8'h99, 1'b0, 1'b1, 1'b1, 1);
    ticks(17);
    pop_info();
    // randomized mix
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          pen = 1'($urandom);
          podd = 1'($urandom);
          bigend = 1'($urandom);
          d = 8'($urandom);
          send(d, (^d ^ podd) ^ ($urandom_range(0, 4) == 0), $urandom_range(0, 9) != 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        3, 4: for (int t = 0; t < $urandom_range(1, 20); t++) tick($urandom_range(0, 4) == 0);
        default: pop_info();
      endcase
    end
    ticks(17);
    // reset mid-frame
    pen = 1'b0;
    send(8'h42, 1'b0, 1'b1, 1'b0, 0);
    rst = 1'b1;
    step();
    model_reset();
    chk("midrst_data", dout, 8'h00);
    check_info();
    rst = 1'b0;
    ticks(20);
    chk("midrst_no_push", ivalid, 1'b0);
    // reset mid-character
    b_in = {1'b0, 8'h77, 1'b0, 1'b1};
    bs = 1'b1;
    step();
    bs = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("midchar_no_write", n_we, 1'b1);
    chk("midchar_data", dout, 8'h00);
    ticks(18);
    check_info();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_frame_tracker.md
RX_FRAME_TRACKER -- requirements
Module: rx_frame_tracker

Interface
REQ-001 Parameter DATA_W, default 8: data bits per character, legal range 5..9.
REQ-002 Parameter INFO_DEPTH, default 4: frame-info FIFO entries, power of two, 2..16.
REQ-003 Parameter CNT_W, default 12: frame byte-count width.
REQ-004 Parameter GAP_BAUDS, default 17: idle baud ticks after the last byte that close a frame; legal range 1..254.
REQ-005 clk  in  1  system clock; one clock domain.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 byte_synch_i  in  1  one-cycle pulse: byte_i holds a complete character.
REQ-008 byte_i  in  DATA_W+3  {start, data MSB-first as shifted, parity, stop}.
REQ-009 baud_sig_i  in  1  one-cycle pulse per baud period.
REQ-010 parity_en_i / parity_odd_i / big_end_i  in  1 each  parity check enable, odd (1) or even (0) parity, bit order select.
REQ-011 ms_stamp_i  in  12 and us100_stamp_i  in  4  time stamp.
REQ-012 n_we_o  out  1  data FIFO write strobe, active-low; data_o  out  DATA_W  character; p_full_i  in  1  data FIFO full.
REQ-013 info_rd_i  in  1  pop frame-info head; info_o  out  16+CNT_W  {us100, ms, count}; info_valid_o  out  1  info FIFO not empty; info_count_o  out  $clog2(INFO_DEPTH)+1  occupancy.
REQ-014 parity_err_o, stop_err_o, data_ovf_o, info_ovf_o  out  1 each  one-cycle error pulses.

Function
REQ-015 FSM states IDLE, CHECK, WRITE: IDLE->CHECK on byte_synch_i; CHECK->WRITE; WRITE->IDLE unconditionally.
REQ-016 Character latched on the byte_synch_i edge (cycle N); state CHECK in N+1; n_we_o low for exactly one cycle in N+2 when the character is accepted.
REQ-017 data_o shall be the data field in received order when big_end_i=1 and bit-reversed when big_end_i=0; data_o is stable from N+2 until the next write.
REQ-018 Parity is computed internally in CHECK: expected parity = XOR(data) XOR parity_odd_i; a mismatch with parity_en_i=1 rejects the character and pulses parity_err_o in N+2.
REQ-019 A stop bit of 0 rejects the character and pulses stop_err_o in N+2; with both faults present, both error pulses fire.
REQ-020 A character with no faults and p_full_i=1 in CHECK is dropped with n_we_o held high, and data_ovf_o pulses in N+2.
REQ-021 byte_synch_i outside IDLE drops the new character and pulses data_ovf_o the next cycle; the FSM is unaffected.
REQ-022 Gap counter (8 bit) is cleared by every byte_synch_i, increments on baud_sig_i, and saturates at 255.
REQ-023 An accepted character with no frame open opens a frame: it captures ms_stamp_i/us100_stamp_i from cycle N and sets the count to 1; later accepted characters increment the count, saturating at 2^CNT_W-1.
REQ-024 When the gap counter reaches GAP_BAUDS with a frame open, the frame closes and {stamp, count} is pushed to the info FIFO; a byte_synch_i in the same cycle takes priority and no close occurs.
REQ-025 info FIFO is first-word-fall-through: info_o shows the head when info_valid_o=1 and shows 0 when empty.
REQ-026 info_rd_i while empty is ignored.
REQ-027 A push into a full info FIFO discards the oldest entry, keeps the occupancy at INFO_DEPTH, and pulses info_ovf_o.
REQ-028 A simultaneous push and pop on a full FIFO pops and then pushes, without info_ovf_o; on an empty FIFO the pushed entry appears on info_o the next cycle.

Reset
REQ-029 While rst=1 the block shall hold: FSM in IDLE, n_we_o=1, data_o=0, info_o=0, info_valid_o=0, info_count_o=0, all error pulses 0, gap counter 255, no frame open, info FIFO empty.
REQ-030 A reset asserted mid-character or mid-frame discards the partial frame with no info push.

Structure
REQ-031 A shared package shall hold the FSM state enumeration, the info-entry field offsets, and the default parameter values.
REQ-032 The info FIFO shall be one sub-module, rx_info_fifo (depth and width parameters, overwrite-oldest policy).

Verification
REQ-033 8N1 with big_end_i=1, character 0xA5 -> n_we_o low in cycle N+2 and data_o=0xA5; with big_end_i=0 -> data_o=0xA5 bit-reversed (0xA5).
REQ-034 Even parity enabled, character 0x03 sent with parity bit 1 -> parity_err_o pulses, no write, count unchanged.
REQ-035 Three characters 10 baud ticks apart, then 17 idle ticks -> one info entry with count=3 and the stamp of the first character.
REQ-036 Six frames with no reads, INFO_DEPTH=4 -> info_ovf_o pulses twice and the head holds the stamp of frame 3.
REQ-037 Full info FIFO with info_rd_i coinciding with a close -> info_count_o stays 4 and no info_ovf_o.
REQ-038 p_full_i=1 during CHECK -> data_ovf_o pulses and n_we_o stays high; rst pulsed mid-frame -> info_valid_o=0 and no later push for that frame.
